// File: rtl/microsequencer_pkg.sv
// Shared constants for the microsequencer and the control unit: next-state
// select codes, fixed sequence entry points and instruction-decode targets.
package microsequencer_pkg;

  localparam int STATE_W_DEF     = 7;
  localparam int FETCH_STATE_DEF = 1;
  localparam int ERR_STATE_DEF   = 127;
  localparam int MOC_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    NS_ZERO     = 3'd0,
    NS_INC      = 3'd1,
    NS_DECODE   = 3'd2,
    NS_CR       = 3'd3,
    NS_MOC_WAIT = 3'd4,
    NS_COND     = 3'd5,
    NS_FETCH    = 3'd6,
    NS_HOLD     = 3'd7
  } ns_sel_e;

  // Entry states of each instruction-class microroutine
  localparam int ST_DP_SHIFT = 10;
  localparam int ST_DP_IMM   = 11;
  localparam int ST_LDR_IMM  = 20;
  localparam int ST_LDR_REG  = 21;
  localparam int ST_STR_IMM  = 30;
  localparam int ST_STR_REG  = 31;
  localparam int ST_B        = 40;
  localparam int ST_BL       = 41;

endpackage

// File: rtl/microsequencer_if.sv
// Control-unit side bundle of the microsequencer: next-state directives and
// condition inputs in, registered state code and timeout pulse out.
interface microsequencer_if #(
  parameter int STATE_W = 7
);
  logic [2:0]         ns_sel;
  logic [STATE_W-1:0] cr;
  logic               inv;
  logic               cond;
  logic               moc;
  logic [31:0]        ir;
  logic               cond_pass;
  logic [STATE_W-1:0] state;
  logic               timeout;

  modport master (
    output ns_sel, cr, inv, cond, moc, ir, cond_pass,
    input  state, timeout
  );

  modport slave (
    input  ns_sel, cr, inv, cond, moc, ir, cond_pass,
    output state, timeout
  );
endinterface

// File: rtl/microsequencer_state_encoder.sv
// Combinational IR-to-microroutine mapping used by the decode directive;
// a failed condition check sends the sequencer straight back to fetch.
module state_encoder
  import microsequencer_pkg::*;
#(
  parameter int STATE_W     = STATE_W_DEF,
  parameter int FETCH_STATE = FETCH_STATE_DEF
) (
  input  logic [31:0]        ir,
  input  logic               cond_pass,
  output logic [STATE_W-1:0] enc_state
);

  logic unused_ir;
  assign unused_ir = ^{ir[31:28], ir[23:21], ir[19:0]};

  // ir[20] selects load vs store, ir[24] selects branch-with-link
  always_comb begin
    enc_state = STATE_W'(FETCH_STATE);
    if (cond_pass) begin
      case (ir[27:25])
        3'b000:  enc_state = STATE_W'(ST_DP_SHIFT);
        3'b001:  enc_state = STATE_W'(ST_DP_IMM);
        3'b010:  enc_state = ir[20] ? STATE_W'(ST_LDR_IMM) : STATE_W'(ST_STR_IMM);
        3'b011:  enc_state = ir[20] ? STATE_W'(ST_LDR_REG) : STATE_W'(ST_STR_REG);
        3'b101:  enc_state = ir[24] ? STATE_W'(ST_BL) : STATE_W'(ST_B);
        default: enc_state = STATE_W'(FETCH_STATE);
      endcase
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: next-state multiplexer, state register and MOC wait counter
// that step the control unit through its microroutines.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int STATE_W     = STATE_W_DEF,
  parameter int FETCH_STATE = FETCH_STATE_DEF,
  parameter int ERR_STATE   = ERR_STATE_DEF,
  parameter int MOC_TIMEOUT = MOC_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  microsequencer_if.slave  bus
);

  localparam int CNT_W = (MOC_TIMEOUT < 1) ? 1 : $clog2(MOC_TIMEOUT + 1);

  ns_sel_e            ns_sel;
  logic [STATE_W-1:0] state_d, state_q;
  logic [STATE_W-1:0] state_inc;
  logic [STATE_W-1:0] enc_state;
  logic [CNT_W-1:0]   wait_cnt_d, wait_cnt_q;
  logic               timeout_d, timeout_q;

  assign ns_sel    = ns_sel_e'(bus.ns_sel);
  assign state_inc = state_q + STATE_W'(1);

  state_encoder #(
    .STATE_W     (STATE_W),
    .FETCH_STATE (FETCH_STATE)
  ) u_state_encoder (
    .ir        (bus.ir),
    .cond_pass (bus.cond_pass),
    .enc_state (enc_state)
  );

  // The wait counter only survives cycles that hold state under NS_MOC_WAIT
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    timeout_d  = 1'b0;
    case (ns_sel)
      NS_ZERO:   state_d = '0;
      NS_INC:    state_d = state_inc;
      NS_DECODE: state_d = enc_state;
      NS_CR:     state_d = bus.cr;
      NS_MOC_WAIT: begin
        if (bus.moc) begin
          state_d = state_inc;
        end else if (wait_cnt_q == CNT_W'(MOC_TIMEOUT)) begin
          state_d   = STATE_W'(ERR_STATE);
          timeout_d = (state_q != STATE_W'(ERR_STATE));
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      NS_COND:   state_d = (bus.cond ^ bus.inv) ? bus.cr : state_inc;
      NS_FETCH:  state_d = STATE_W'(FETCH_STATE);
      NS_HOLD:   state_d = state_q;
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed scoreboard bench for the microsequencer: the driver queues the
// hand-computed state/timeout expected after each edge, the monitor checks them.
module tb_microsequencer;
  import microsequencer_pkg::*;

  typedef struct {
    string      name;
    logic [6:0] st;
    logic       to;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  microsequencer_if #(.STATE_W(7)) bus ();

  microsequencer #(
    .STATE_W     (7),
    .FETCH_STATE (1),
    .ERR_STATE   (127),
    .MOC_TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares after every clock edge and every reset assertion
  always @(posedge clk or posedge reset) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.state !== e.st) begin
        errors++;
        $display("FAIL %s: state=%0d expected %0d", e.name, bus.state, e.st);
      end
      checks++;
      if (bus.timeout !== e.to) begin
        errors++;
        $display("FAIL %s: timeout=%0b expected %0b", e.name, bus.timeout, e.to);
      end
    end
  end

  task automatic drive(input logic [2:0] ns, input int crv, input logic iv, input logic cd,
                       input logic mc, input logic [31:0] irv, input logic cp,
                       input int est, input logic eto, input string nm);
    exp_t e;
    bus.ns_sel    = ns;
    bus.cr        = 7'(crv);
    bus.inv       = iv;
    bus.cond      = cd;
    bus.moc       = mc;
    bus.ir        = irv;
    bus.cond_pass = cp;
    e.name = nm;
    e.st   = 7'(est);
    e.to   = eto;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [2:0] ns, input int crv, input logic iv, input logic cd,
                      input logic mc, input logic [31:0] irv, input logic cp,
                      input int est, input logic eto, input string nm);
    @(negedge clk);
    drive(ns, crv, iv, cd, mc, irv, cp, est, eto, nm);
  endtask

  initial begin
    exp_t e;
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    bus.ns_sel    = NS_HOLD;
    bus.cr        = '0;
    bus.inv       = 1'b0;
    bus.cond      = 1'b0;
    bus.moc       = 1'b0;
    bus.ir        = '0;
    bus.cond_pass = 1'b0;

    #3;
    e.name = "reset_init"; e.st = 7'd0; e.to = 1'b0;
    exp_q.push_back(e);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(NS_INC, 0, 0, 0, 0, 0, 0, 1, 0, "first_edge_after_reset");
    step(NS_INC, 0, 0, 0, 0, 0, 0, 2, 0, "inc_2");
    step(NS_INC, 0, 0, 0, 0, 0, 0, 3, 0, "inc_3");
    step(NS_CR, 127, 0, 0, 0, 0, 0, 127, 0, "cr_127");
    step(NS_INC, 0, 0, 0, 0, 0, 0, 0, 0, "inc_wrap");
    step(NS_CR, 35, 0, 0, 0, 0, 0, 35, 0, "cr_35");

    // Pending branch to 50 is cut off by an asynchronous reset mid-cycle
    @(negedge clk);
    bus.ns_sel = NS_COND; bus.cr = 7'd50; bus.cond = 1'b1; bus.inv = 1'b0;
    #2;
    e.name = "async_reset_at_35"; e.st = 7'd0; e.to = 1'b0;
    exp_q.push_back(e);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(NS_HOLD, 0, 0, 0, 0, 0, 0, 0, 0, "pending_branch_discarded");

    step(NS_COND, 50, 0, 1, 0, 0, 0, 50, 0, "branch_c1_i0");
    step(NS_CR, 5, 0, 0, 0, 0, 0, 5, 0, "cr_5");
    step(NS_COND, 50, 1, 0, 0, 0, 0, 50, 0, "branch_c0_i1");
    step(NS_COND, 50, 1, 1, 0, 0, 0, 51, 0, "branch_c1_i1_falls");
    step(NS_COND, 50, 0, 0, 0, 0, 0, 52, 0, "branch_c0_i0_falls");

    for (int i = 0; i < 3; i++) step(NS_MOC_WAIT, 0, 0, 0, 0, 0, 0, 52, 0, "moc_short_wait");
    step(NS_MOC_WAIT, 0, 0, 0, 1, 0, 0, 53, 0, "moc_short_done");

    for (int i = 0; i < 15; i++) step(NS_MOC_WAIT, 0, 0, 0, 0, 0, 0, 53, 0, "moc_to_wait");
    step(NS_MOC_WAIT, 0, 0, 0, 0, 0, 0, 127, 1, "moc_timeout_entry");
    step(NS_HOLD, 0, 0, 0, 0, 0, 0, 127, 0, "timeout_single_pulse");
    step(NS_HOLD, 0, 0, 0, 0, 0, 0, 127, 0, "err_state_held");

    // Leaving the wait for one cycle must restart the count from zero
    step(NS_CR, 60, 0, 0, 0, 0, 0, 60, 0, "cr_60");
    for (int i = 0; i < 5; i++) step(NS_MOC_WAIT, 0, 0, 0, 0, 0, 0, 60, 0, "moc_partial_wait");
    step(NS_HOLD, 0, 0, 0, 0, 0, 0, 60, 0, "hold_clears_count");
    for (int i = 0; i < 15; i++) step(NS_MOC_WAIT, 0, 0, 0, 0, 0, 0, 60, 0, "moc_race_wait");
    step(NS_MOC_WAIT, 0, 0, 0, 1, 0, 0, 61, 0, "moc_wins_at_limit");
    step(NS_HOLD, 0, 0, 0, 0, 0, 0, 61, 0, "no_timeout_after_race");

    step(NS_FETCH, 0, 0, 0, 0, 0, 0, 1, 0, "goto_fetch");
    step(NS_ZERO, 0, 0, 0, 0, 0, 0, 0, 0, "goto_zero");

    step(NS_DECODE, 0, 0, 0, 0, 32'hE590_0000, 1, 20, 0, "dec_ldr_imm");
    step(NS_DECODE, 0, 0, 0, 0, 32'hE580_0000, 1, 30, 0, "dec_str_imm");
    step(NS_DECODE, 0, 0, 0, 0, 32'hEB00_0000, 1, 41, 0, "dec_bl");
    step(NS_DECODE, 0, 0, 0, 0, 32'hEA00_0000, 1, 40, 0, "dec_b");
    step(NS_DECODE, 0, 0, 0, 0, 32'hE000_0000, 1, 10, 0, "dec_dp_shift");
    step(NS_DECODE, 0, 0, 0, 0, 32'hE200_0000, 1, 11, 0, "dec_dp_imm");
    step(NS_DECODE, 0, 0, 0, 0, 32'hE790_0000, 1, 21, 0, "dec_ldr_reg");
    step(NS_DECODE, 0, 0, 0, 0, 32'hE780_0000, 1, 31, 0, "dec_str_reg");
    step(NS_DECODE, 0, 0, 0, 0, 32'hE800_0000, 1, 1, 0, "dec_other_class");
    step(NS_DECODE, 0, 0, 0, 0, 32'hE590_0000, 0, 1, 0, "dec_cond_fail");

    @(negedge clk);
    bus.ns_sel = NS_HOLD;
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending expectations, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
